// File: rtl/servo_pwm_pkg.sv
// Shared timing defaults and the pulse-width clamp for the servo PWM bank.
package servo_pwm_pkg;

    localparam int unsigned PERIOD_CYC = 540540;
    localparam int unsigned WIDTH_MIN  = 13514;
    localparam int unsigned WIDTH_MAX  = 67568;

    // Zero passes through untouched so that a write of 0 switches a channel off.
    function automatic logic [31:0] clamp_width(
        input logic [31:0] value,
        input logic [31:0] min_w,
        input logic [31:0] max_w
    );
        logic [31:0] res;
        res = value;
        if (value == 32'd0) begin
            res = 32'd0;
        end else if (value < min_w) begin
            res = min_w;
        end else if (value > max_w) begin
            res = max_w;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: shadow/active width registers, enable, slew and
// output compare.
module servo_pwm_channel #(
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned WIDTH_MIN = 13514,
    parameter int unsigned SLEW_STEP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_width,
    input  logic             boundary,
    input  logic             en_in,
    input  logic [CNT_W-1:0] cnt_next,
    output logic             pwm
);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] active_nxt;
    logic             en;
    logic             en_nxt;
    logic [CNT_W:0]   base;
    logic [CNT_W:0]   tgt;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   step;

    always_comb begin
        active_nxt = active;
        en_nxt     = en;
        tgt        = {1'b0, shadow};
        step       = (CNT_W+1)'(SLEW_STEP);
        base       = {1'b0, active};
        diff       = '0;
        if (boundary) begin
            en_nxt = en_in;
            if (SLEW_STEP == 0 || shadow == '0) begin
                active_nxt = shadow;
            end else begin
                // A ramp out of the off state begins at the minimum legal width.
                if (active == '0) begin
                    base = (CNT_W+1)'(WIDTH_MIN);
                end
                if (tgt >= base) begin
                    diff       = tgt - base;
                    active_nxt = CNT_W'((diff > step) ? base + step : tgt);
                end else begin
                    diff       = base - tgt;
                    active_nxt = CNT_W'((diff > step) ? base - step : tgt);
                end
            end
        end
    end

    // The compare uses next-cycle values so the pulse starts alongside cnt==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            en     <= 1'b0;
            pwm    <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= wr_width;
            end
            active <= active_nxt;
            en     <= en_nxt;
            pwm    <= en_nxt && (cnt_next < active_nxt);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: shared period counter, write port with
// clamping, frame strobe and one channel instance per output.
module servo_pwm_bank #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned PERIOD_CYC = servo_pwm_pkg::PERIOD_CYC,
    parameter int unsigned WIDTH_MIN  = servo_pwm_pkg::WIDTH_MIN,
    parameter int unsigned WIDTH_MAX  = servo_pwm_pkg::WIDTH_MAX,
    parameter int unsigned SLEW_STEP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_width,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  pwm_out,
    output logic             frame_start,
    output logic             clamp_pulse
);

    import servo_pwm_pkg::*;

    if (WIDTH_MAX >= PERIOD_CYC) begin : g_chk_max
        $error("WIDTH_MAX must be below PERIOD_CYC");
    end
    if (WIDTH_MIN > WIDTH_MAX) begin : g_chk_min
        $error("WIDTH_MIN must not exceed WIDTH_MAX");
    end
    if (CNT_W > 32 || 64'(PERIOD_CYC) >= (64'd1 << CNT_W)) begin : g_chk_cnt
        $error("PERIOD_CYC does not fit in CNT_W");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] clamped;
    logic             boundary;
    logic             ready_q;
    logic             accept;
    logic             ch_ok;

    assign boundary = (cnt == CNT_W'(PERIOD_CYC - 1));
    assign cnt_next = boundary ? '0 : cnt + CNT_W'(1);

    assign wr_ready = ready_q && !rst && !boundary;
    assign accept   = wr_valid && wr_ready;
    assign ch_ok    = (32'(wr_ch) < N_CH);
    assign clamped  = CNT_W'(clamp_width(32'(wr_width), WIDTH_MIN, WIDTH_MAX));

    assign frame_start = !rst && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            ready_q     <= 1'b0;
            clamp_pulse <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            ready_q     <= 1'b1;
            clamp_pulse <= accept && ch_ok && (clamped != wr_width);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_pwm_channel #(
            .CNT_W     (CNT_W),
            .WIDTH_MIN (WIDTH_MIN),
            .SLEW_STEP (SLEW_STEP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (accept && ch_ok && (wr_ch == CH_W'(i))),
            .wr_width (clamped),
            .boundary (boundary),
            .en_in    (ch_en[i]),
            .cnt_next (cnt_next),
            .pwm      (pwm_out[i])
        );
    end

endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
Multi-channel servo PWM generator; parametrised successor of the single-channel servo PWM block.
- One shared period counter drives N_CH independent pulse outputs.
- Each channel has a shadow width register written over a valid/ready port and copied to the active register only at a period boundary, so pulses are glitch-free.
- Adds a per-channel enable, clamping with a report pulse, optional slew limiting, and a frame-start strobe for the UART command path.

Parameters:
N_CH, 4, number of PWM channels (1..16)
CH_W, 2, channel index width, equal to clog2(N_CH) with minimum 1
CNT_W, 20, counter/width bit width
PERIOD_CYC, 540540, period length in clk cycles (20 ms at 37 ns)
WIDTH_MIN, 13514, minimum nonzero pulse in cycles (0.5 ms)
WIDTH_MAX, 67568, maximum pulse in cycles (2.5 ms)
SLEW_STEP, 0, max change of active width per period; 0 = unlimited

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_valid  in  1  width write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_ch  in  CH_W  target channel
wr_width  in  CNT_W  requested pulse width in cycles
ch_en  in  N_CH  per-channel enable
pwm_out  out  N_CH  pulse outputs
frame_start  out  1  one-cycle strobe at start of each period
clamp_pulse  out  1  one-cycle strobe: last accepted write was clamped

Behaviour:
- Reset, applied on the clk edge with rst high:
  - cnt=0; all shadow and active widths = 0; active enables = 0.
  - pwm_out=0, frame_start=0, clamp_pulse=0, wr_ready=0.
  - wr_ready rises the first cycle after rst falls.
  - Reset mid-period: every output is low the next cycle; no partial pulse completes.
- Counter:
  - cnt counts 0..PERIOD_CYC-1, then wraps to 0.
  - frame_start=1 in exactly the cycles where registered cnt==0, excluding the cycle rst is high.
- Boundary (the cycle with cnt==PERIOD_CYC-1):
  - Each channel's active width is loaded from its shadow.
  - Each channel's active enable is loaded from ch_en.
  - The new values govern the period starting at the next cnt==0.
- Write handshake:
  - wr_ready=0 in the boundary cycle and during reset; 1 otherwise.
  - An accepted write updates the shadow on the next edge.
  - A write accepted in the cycle with cnt==PERIOD_CYC-2 reaches the shadow in time and takes effect in the next period.
  - Multiple writes to one channel within a period: the last one wins.
  - wr_ch >= N_CH: the write is accepted and discarded, with no clamp_pulse.
- Clamping, applied on write:
  - 0 is stored as 0 and means the channel is off.
  - 1..WIDTH_MIN-1 is stored as WIDTH_MIN.
  - Values above WIDTH_MAX are stored as WIDTH_MAX.
  - clamp_pulse=1 the cycle after an accepted in-range-channel write whose value was modified.
- Slew (SLEW_STEP>0), at the boundary:
  - active moves toward shadow by min(|shadow-active|, SLEW_STEP).
  - A shadow of 0 forces active=0 immediately, with no slew.
  - A move away from 0 starts from WIDTH_MIN.
- Output:
  - pwm_out[i] is registered and equals 1 when active_en[i] && cnt < active[i], evaluated on the current cnt.
  - It therefore lags frame_start by 0 cycles relative to cnt==0.
  - Pulse high time is exactly active[i] cycles; width 0 or enable 0 keeps the output low for the whole period.
- Arithmetic: all comparisons unsigned at CNT_W. The slew subtraction is computed at CNT_W+1 bits and never wraps.
- Elaboration-time checks: WIDTH_MAX < PERIOD_CYC, WIDTH_MIN <= WIDTH_MAX, and PERIOD_CYC < 2^CNT_W.

Decomposition:
- Package servo_pwm_pkg holds:
  - default timing constants: PERIOD_CYC, WIDTH_MIN, WIDTH_MAX;
  - clamp function clamp_width(value, min, max) implementing the zero-passes-through rule.
- Sub-module servo_pwm_channel holds one channel:
  - shadow register, active register and enable, slew logic, output compare.
  - It is instantiated N_CH times from a generate loop.
- The top level keeps the counter, handshake, write decode, frame_start and clamp_pulse.

Test Plan:
1. Bench parameters N_CH=2, PERIOD_CYC=100, WIDTH_MIN=10, WIDTH_MAX=50, SLEW_STEP=0. Write ch0=30 at cnt=5 with ch_en=11 -> ch0 stays low for the rest of that period; from the next frame_start, pwm_out[0] is high for exactly 30 cycles per period; pwm_out[1] stays 0.
2. Write ch1=80, then ch1=3 -> clamp_pulse asserted once per write; the next period ch1 is high for 10 cycles (last write wins).
3. Hold wr_valid with cnt==99 -> wr_ready=0 that cycle; the write is accepted at cnt==0 and applies one period later.
4. ch0 active at 30; pulse rst for 1 cycle at cnt=12 -> pwm_out=00 the next cycle; after release, cnt restarts at 0, all widths are 0, outputs stay low.
5. SLEW_STEP=8, ch0 active at 10, write 40 -> successive periods use 18, 26, 34, 40; then write 0 -> the next period is 0.
6. Write ch0=20 and deassert ch_en[0] mid-period -> the current pulse finishes; the next period stays low; re-enable -> 20-cycle pulses resume at the following period.
